// File: rtl/prog_clk_div_pkg.sv
// Shared types and helpers for the multi-channel programmable clock divider.
package prog_clk_div_pkg;

   localparam int DIV_MIN   = 2;
   localparam int DIV_MAX_W = 64;

   typedef logic [DIV_MAX_W-1:0] divWide_t;

   typedef enum logic {
      PH_LOW  = 1'b0,
      PH_HIGH = 1'b1
   } phase_e;

   function automatic divWide_t clampDiv(input divWide_t n);
      return (n < divWide_t'(DIV_MIN)) ? divWide_t'(DIV_MIN) : n;
   endfunction

   // Odd divisors give the spare cycle to the high phase.
   function automatic divWide_t lowLen(input divWide_t n);
      return n >> 1;
   endfunction

   function automatic divWide_t highLen(input divWide_t n);
      return n - (n >> 1);
   endfunction

endpackage

// File: rtl/prog_clk_div_chan.sv
// One divider channel: phase counter, LOW/HIGH FSM and shadow divisor.
// Tick register exists only when PROG_CLK_DIV_TICK_EN is defined.
module prog_clk_div_chan
   import prog_clk_div_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int DEFAULT_DIV = 25_000_000
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enable_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] value_i,
   output logic             clkOut_o,
   output logic             tick_o,
   output logic             pending_o
);

   localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(clampDiv(divWide_t'(DEFAULT_DIV)));

   phase_e           phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] activeDiv_q, activeDiv_d;
   logic [CNT_W-1:0] shadowDiv_q, shadowDiv_d;
   logic             pending_q, pending_d;
   logic [CNT_W-1:0] lowLast, highLast;
   logic             applyNow;

   assign lowLast  = CNT_W'(lowLen(divWide_t'(activeDiv_q)) - divWide_t'(1));
   assign highLast = CNT_W'(highLen(divWide_t'(activeDiv_q)) - divWide_t'(1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q     <= PH_LOW;
         cnt_q       <= '0;
         activeDiv_q <= RESET_DIV;
         shadowDiv_q <= RESET_DIV;
         pending_q   <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         activeDiv_q <= activeDiv_d;
         shadowDiv_q <= shadowDiv_d;
         pending_q   <= pending_d;
      end
   end

   // A pending divisor is taken on the LOW->HIGH step so the new high phase
   // already runs at the new length; a disabled channel takes it at once.
   always_comb begin
      phase_d     = phase_q;
      cnt_d       = cnt_q;
      activeDiv_d = activeDiv_q;
      shadowDiv_d = shadowDiv_q;
      pending_d   = pending_q;
      applyNow    = 1'b0;
      if (!enable_i) begin
         phase_d  = PH_LOW;
         cnt_d    = '0;
         applyNow = pending_q;
      end else if (phase_q == PH_LOW) begin
         if (cnt_q == lowLast) begin
            phase_d  = PH_HIGH;
            cnt_d    = '0;
            applyNow = pending_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         if (cnt_q == highLast) begin
            phase_d = PH_LOW;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      if (applyNow) begin
         activeDiv_d = shadowDiv_q;
         pending_d   = 1'b0;
      end
      if (load_i) begin
         shadowDiv_d = CNT_W'(clampDiv(divWide_t'(value_i)));
         pending_d   = 1'b1;
      end
   end

   always_comb begin
      clkOut_o  = (phase_q == PH_HIGH);
      pending_o = pending_q;
   end

`ifdef PROG_CLK_DIV_TICK_EN
   logic tick_q, tick_d;

   assign tick_d = (phase_q == PH_LOW) && (phase_d == PH_HIGH);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;
`else
   assign tick_o = 1'b0;
`endif

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider top: load decode plus one channel per output.
// Define PROG_CLK_DIV_TICK_EN to generate the per-channel tick pulses.
module prog_clk_div
   import prog_clk_div_pkg::*;
#(
   parameter int CHANNELS    = 2,
   parameter int CNT_W       = 32,
   parameter int DEFAULT_DIV = 25_000_000,
   parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic [CHANNELS-1:0] enable,
   input  logic                div_load,
   input  logic [CH_W-1:0]     div_ch,
   input  logic [CNT_W-1:0]    div_value,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] pending
);

   logic [CHANNELS-1:0] loadSel;

   // Selects that match no channel leave every channel untouched.
   always_comb begin
      loadSel = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (div_load && (div_ch == CH_W'(i))) begin
            loadSel[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : gChan
      prog_clk_div_chan #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) uChan (
         .clk_i     (sys_clk),
         .rst_ni    (sys_rst_n),
         .enable_i  (enable[g]),
         .load_i    (loadSel[g]),
         .value_i   (div_value),
         .clkOut_o  (clk_out[g]),
         .tick_o    (tick[g]),
         .pending_o (pending[g])
      );
   end

endmodule

// File: tb/tb_prog_clk_div.sv
// Scoreboard bench for prog_clk_div: a period-position reference model queues
// expected outputs per cycle, a monitor pops and compares after each rising edge.
module tb_prog_clk_div;

   localparam int CHANNELS    = 3;
   localparam int CNT_W       = 16;
   localparam int DEFAULT_DIV = 8;
   localparam int CH_W        = 2;

   logic                sys_clk   = 1'b0;
   logic                sys_rst_n = 1'b0;
   logic [CHANNELS-1:0] enable    = '0;
   logic                div_load  = 1'b0;
   logic [CH_W-1:0]     div_ch    = '0;
   logic [CNT_W-1:0]    div_value = '0;
   logic [CHANNELS-1:0] clk_out;
   logic [CHANNELS-1:0] tick;
   logic [CHANNELS-1:0] pending;

   typedef struct packed {
      logic [CHANNELS-1:0] clkOut;
      logic [CHANNELS-1:0] tick;
      logic [CHANNELS-1:0] pending;
   } expect_t;

   expect_t expQ[$];
   int      testsRun    = 0;
   int      testsFailed = 0;

   // Model: each period is lowLen low cycles then the (possibly new) high length.
   int modelAct[CHANNELS];
   int modelShadow[CHANNELS];
   int modelPos[CHANNELS];
   int modelLowLen[CHANNELS];
   bit modelPend[CHANNELS];

   prog_clk_div #(
      .CHANNELS    (CHANNELS),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .enable    (enable),
      .div_load  (div_load),
      .div_ch    (div_ch),
      .div_value (div_value),
      .clk_out   (clk_out),
      .tick      (tick),
      .pending   (pending)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic int clampRef(input int n);
      return (n < 2) ? 2 : n;
   endfunction

   task automatic resetModel();
      for (int c = 0; c < CHANNELS; c++) begin
         modelAct[c]    = clampRef(DEFAULT_DIV);
         modelShadow[c] = modelAct[c];
         modelPos[c]    = 0;
         modelLowLen[c] = modelAct[c] / 2;
         modelPend[c]   = 1'b0;
      end
   endtask

   task automatic checkOutput(input string name, input logic [CHANNELS-1:0] got,
                              input logic [CHANNELS-1:0] want);
      testsRun++;
      if (got !== want) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, got, want, $time);
      end
   endtask

   // Drives one cycle of inputs at the falling edge and queues the outputs
   // expected after the following rising edge.
   task automatic applyStimulus(input logic [CHANNELS-1:0] en, input logic ld,
                                input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] val);
      expect_t e;
      bit      rise;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      enable    = en;
      div_load  = ld;
      div_ch    = ch;
      div_value = val;
      e = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         rise = 1'b0;
         if (!en[c]) begin
            if (modelPend[c]) begin
               modelAct[c]  = modelShadow[c];
               modelPend[c] = 1'b0;
            end
            modelPos[c]    = 0;
            modelLowLen[c] = modelAct[c] / 2;
         end else begin
            modelPos[c]++;
            if (modelPos[c] == modelLowLen[c]) begin
               rise = 1'b1;
               if (modelPend[c]) begin
                  modelAct[c]  = modelShadow[c];
                  modelPend[c] = 1'b0;
               end
            end else if (modelPos[c] == modelLowLen[c] + modelAct[c] - modelAct[c] / 2) begin
               modelPos[c]    = 0;
               modelLowLen[c] = modelAct[c] / 2;
            end
         end
         if (ld && (int'(ch) == c)) begin
            modelShadow[c] = clampRef(int'(val));
            modelPend[c]   = 1'b1;
         end
         e.clkOut[c]  = (modelPos[c] >= modelLowLen[c]);
         e.pending[c] = modelPend[c];
`ifdef PROG_CLK_DIV_TICK_EN
         e.tick[c] = rise;
`else
         e.tick[c] = 1'b0;
`endif
      end
      expQ.push_back(e);
   endtask

   task automatic idle(input int n, input logic [CHANNELS-1:0] en);
      for (int i = 0; i < n; i++) applyStimulus(en, 1'b0, '0, '0);
   endtask

   // Asserts reset between edges and expects every output to clear at once.
   task automatic doReset();
      @(posedge sys_clk);
      #3;
      sys_rst_n = 1'b0;
      #1;
      checkOutput("async_reset_clk_out", clk_out, '0);
      checkOutput("async_reset_tick", tick, '0);
      checkOutput("async_reset_pending", pending, '0);
      resetModel();
   endtask

   initial begin : monitor
      expect_t e;
      forever begin
         @(posedge sys_clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("clk_out", clk_out, e.clkOut);
            checkOutput("tick", tick, e.tick);
            checkOutput("pending", pending, e.pending);
         end
      end
   end

   initial begin : stimulus
      logic [CHANNELS-1:0] en;
      logic                ld;
      logic [CH_W-1:0]     ch;
      logic [CNT_W-1:0]    val;

      resetModel();
      #2;
      checkOutput("reset_clk_out", clk_out, '0);
      checkOutput("reset_tick", tick, '0);
      checkOutput("reset_pending", pending, '0);
      repeat (2) @(posedge sys_clk);

      idle(20, 3'b111);
      applyStimulus(3'b111, 1'b1, 2'd0, 16'd5);
      idle(20, 3'b111);
      idle(5, 3'b111);
      applyStimulus(3'b111, 1'b1, 2'd1, 16'd4);
      applyStimulus(3'b111, 1'b1, 2'd1, 16'd6);
      idle(24, 3'b111);
      applyStimulus(3'b111, 1'b1, 2'd2, 16'd0);
      idle(10, 3'b111);
      applyStimulus(3'b111, 1'b1, 2'd0, 16'd1);
      idle(10, 3'b111);
      applyStimulus(3'b111, 1'b1, 2'd3, 16'd3);
      idle(10, 3'b111);
      applyStimulus(3'b111, 1'b1, 2'd0, 16'd8);
      idle(6, 3'b111);
      idle(3, 3'b110);
      applyStimulus(3'b110, 1'b1, 2'd0, 16'd3);
      idle(3, 3'b110);
      applyStimulus(3'b111, 1'b1, 2'd0, 16'd8);
      idle(14, 3'b111);
      idle(5, 3'b111);
      doReset();
      idle(20, 3'b111);

      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < CHANNELS; c++) en[c] = ($urandom_range(0, 15) != 0);
         ld  = ($urandom_range(0, 5) == 0);
         ch  = CH_W'($urandom_range(0, 3));
         val = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(0, 300))
                                           : CNT_W'($urandom_range(0, 13));
         applyStimulus(en, ld, ch, val);
         if (i == 1500) doReset();
      end

      for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge sys_clk);
      #2;
      if (expQ.size() != 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", expQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
